uart_tx_arbiter: RTL and testbench

//  Round-robin scheduler sharing one uart_top transmitter between NUM_REQ byte-stream requesters.

---
 rtl/uart_tx_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, burst-locked scheduler that shares one UART transmitter among NUM_REQ
// byte-stream requesters, with a watchdog on the tx_start -> tx_busy handshake.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_BURST    = 16,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_start,
    input  logic                          tx_busy,
    output logic                          arb_busy,
    output logic                          err_timeout
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW1   = PTR_W + 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam int WDG_W = $clog2(BUSY_TIMEOUT + 1);

    // state     | meaning
    // S_IDLE    | no owner; arbitrate once the UART is quiet
    // S_START   | tx_start pulse for the latched byte; watchdog cleared
    // S_WAIT_HI | waiting for tx_busy to rise, watchdog running
    // S_WAIT_LO | frame in progress, waiting for tx_busy to fall
    // S_NEXT    | owner keeps the lock until last/MAX_BURST releases it
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO,
        S_NEXT
    } state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]        burst_cnt_q, burst_cnt_d;
    logic [WDG_W-1:0]        wdog_q, wdog_d;
    logic                    last_q, last_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_start_q, tx_start_d;
    logic                    arb_busy_q, arb_busy_d;
    logic                    err_q, err_d;

    logic [DATA_WIDTH-1:0]   req_byte [NUM_REQ];
    logic [PTR_W-1:0]        win_idx;
    logic                    win_found;
    logic [PW1-1:0]          cand;
    logic [WDG_W-1:0]        wdog_inc;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_byte[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Search starts just after the last owner, so that owner ends up lowest priority.
    always_comb begin
        win_idx   = ptr_q;
        win_found = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + PW1'(k);
            if (cand >= PW1'(NUM_REQ)) begin
                cand = cand - PW1'(NUM_REQ);
            end
            if (!win_found && req_valid[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
    end

    assign wdog_inc = wdog_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        burst_cnt_d = burst_cnt_q;
        wdog_d      = wdog_q;
        last_d      = last_q;
        grant_d     = grant_q;
        tx_data_d   = tx_data_q;
        err_d       = err_q;
        req_ready   = '0;

        unique case (state_q)
            S_IDLE: begin
                if (win_found && !tx_busy) begin
                    req_ready   = NUM_REQ'(1) << win_idx;
                    tx_data_d   = req_byte[win_idx];
                    last_d      = req_last[win_idx];
                    grant_d     = NUM_REQ'(1) << win_idx;
                    burst_cnt_d = CNT_W'(1);
                    ptr_d       = win_idx;
                    state_d     = S_START;
                end
            end
            S_START: begin
                wdog_d  = '0;
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (tx_busy) begin
                    state_d = S_WAIT_LO;
                end else begin
                    wdog_d = wdog_inc;
                    if (wdog_inc == WDG_W'(BUSY_TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = S_NEXT;
                    end
                end
            end
            S_WAIT_LO: begin
                if (!tx_busy) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (last_q || burst_cnt_q == CNT_W'(MAX_BURST)) begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end else if (req_valid[ptr_q]) begin
                    req_ready   = NUM_REQ'(1) << ptr_q;
                    tx_data_d   = req_byte[ptr_q];
                    last_d      = req_last[ptr_q];
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    state_d     = S_START;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A byte handed over during reset would be silently dropped.
        if (rst) begin
            req_ready = '0;
        end

        tx_start_d = (state_d == S_START);
        arb_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= PTR_W'(NUM_REQ - 1);
            burst_cnt_q <= '0;
            wdog_q      <= '0;
            last_q      <= 1'b0;
            grant_q     <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            arb_busy_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            burst_cnt_q <= burst_cnt_d;
            wdog_q      <= wdog_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            arb_busy_q  <= arb_busy_d;
            err_q       <= err_d;
        end
    end

    assign grant       = grant_q;
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign arb_busy    = arb_busy_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: arbitration vector table, hand-written corner sequences and
// random traffic checked against a transaction-level model of the rotating scheduler.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int BT = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    grant;
    logic [DW-1:0]   tx_data;
    logic            tx_start;
    logic            tx_busy;
    logic            arb_busy;
    logic            err_timeout;

    logic u_busy, foreign;
    assign tx_busy = u_busy | foreign;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .BUSY_TIMEOUT(BT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .grant(grant),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .arb_busy(arb_busy), .err_timeout(err_timeout)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } byte_t;

    typedef struct packed {
        logic [2:0]   prev;   // 7 = straight out of reset
        logic [N-1:0] valid;
        logic [N-1:0] ready;
    } vec_t;

    byte_t dq [N][$];          // what each requester is presenting
    byte_t mq [N][$];          // model's view of pending bytes
    logic [N-1:0] svc [$];     // grant seen at each tx_start
    logic [N-1:0] exp_log [$];

    int n_checks = 0;
    int n_err    = 0;

    int m_owner, m_ptr, m_cnt;
    int u_state, u_dly, u_hi;
    bit stall;
    logic prev_start;
    logic [N-1:0] last_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name, input int cyc);
        n_checks++;
        n_err++;
        $display("FAIL %s: no completion within %0d cycles, expected idle", name, cyc);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (dq[i].size() > 0) begin
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = dq[i][0].data;
                req_last[i]           = dq[i][0].last;
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = DW'($urandom);
                req_last[i]           = 1'($urandom);
            end
        end
    endtask

    task automatic push(input int i, input logic [DW-1:0] d, input logic l);
        byte_t b;
        b.data = d;
        b.last = l;
        dq[i].push_back(b);
        mq[i].push_back(b);
        drive_inputs();
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (dq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Rotating priority with burst lock, evaluated once per transmitted byte.
    task automatic model_tx();
        int    w, j;
        byte_t b;
        if (m_owner < 0) begin
            w = -1;
            for (int k = 1; k <= N; k++) begin
                j = (m_ptr + k) % N;
                if (w < 0 && mq[j].size() > 0) w = j;
            end
            if (w < 0) begin
                check("tx_start_unexpected", 32'(tx_start), 32'd0);
                return;
            end
            m_owner = w;
            m_ptr   = w;
            m_cnt   = 0;
        end
        if (mq[m_owner].size() == 0) begin
            check("tx_start_owner_empty", 32'(tx_start), 32'd0);
            return;
        end
        b = mq[m_owner].pop_front();
        m_cnt++;
        svc.push_back(grant);
        check("tx_grant", 32'(grant), 32'(1) << m_owner);
        check("tx_data", 32'(tx_data), 32'(b.data));
        if (b.last || m_cnt == MB) m_owner = -1;
    endtask

    task automatic step();
        logic [N-1:0] acc;
        @(negedge clk);
        last_ready = req_ready;
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (acc[i] === 1'b1) void'(dq[i].pop_front());
        drive_inputs();
        case (u_state)
            1: if (u_dly == 0) begin
                   u_busy  = 1'b1;
                   u_hi    = $urandom_range(1, 5);
                   u_state = 2;
               end else u_dly--;
            2: if (u_hi == 0) begin
                   u_busy  = 1'b0;
                   u_state = 0;
               end else u_hi--;
            default: ;
        endcase
        if (tx_start === 1'b1) begin
            check("tx_start_width", 32'(prev_start), 32'd0);
            model_tx();
            if (!stall) begin
                u_state = 1;
                u_dly   = $urandom_range(0, 2);
            end
        end
        prev_start = tx_start;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_idle(input string name, input int maxc);
        int c;
        c = 0;
        do begin
            step();
            c++;
        end while (!(all_empty() && u_state == 0 && arb_busy === 1'b0) && c < maxc);
        if (!(all_empty() && u_state == 0 && arb_busy === 1'b0)) fail_timeout(name, maxc);
        check({name, "_grant"}, 32'(grant), 32'd0);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = N - 1;
        m_cnt   = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            dq[i].delete();
            mq[i].delete();
        end
        model_reset();
        u_busy = 1'b0; u_state = 0; foreign = 1'b0; stall = 1'b0;
        drive_inputs();
        step();
        step();
        rst = 1'b0;
        prev_start = 1'b0;
        svc.delete();
    endtask

    task automatic check_log(input string name);
        check({name, "_len"}, 32'(svc.size()), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < svc.size(); i++)
            check({name, "_order"}, 32'(svc[i]), 32'(exp_log[i]));
    endtask

    vec_t vecs [9];

    initial begin
        #900000;
        $display("FAIL global_timeout: bench still running, expected completion");
        $fatal(1);
    end

    initial begin
        int c;
        vecs[0] = '{3'd7, 4'b1111, 4'b0001};
        vecs[1] = '{3'd7, 4'b1010, 4'b0010};
        vecs[2] = '{3'd7, 4'b1000, 4'b1000};
        vecs[3] = '{3'd0, 4'b1111, 4'b0010};
        vecs[4] = '{3'd1, 4'b1011, 4'b1000};
        vecs[5] = '{3'd3, 4'b1111, 4'b0001};
        vecs[6] = '{3'd2, 4'b0100, 4'b0100};
        vecs[7] = '{3'd3, 4'b0000, 4'b0000};
        vecs[8] = '{3'd1, 4'b0011, 4'b0001};

        rst = 1'b1; u_busy = 1'b0; foreign = 1'b0; stall = 1'b0; prev_start = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;
        do_reset();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_arb_busy", 32'(arb_busy), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);

        // single byte, accept at T, tx_start at T+1
        push(0, 8'hA5, 1'b1);
        step();
        check("t1_ready", 32'(last_ready), 32'h1);
        check("t1_tx_start", 32'(tx_start), 32'd1);
        check("t1_tx_data", 32'(tx_data), 32'hA5);
        check("t1_arb_busy", 32'(arb_busy), 32'd1);
        run_idle("t1", 100);

        // foreign frame on the UART blocks arbitration
        do_reset();
        foreign = 1'b1;
        push(0, 8'h42, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("foreign_ready", 32'(last_ready), 32'd0);
        end
        foreign = 1'b0;
        step();
        check("foreign_release_ready", 32'(last_ready), 32'h1);
        run_idle("foreign", 100);

        foreach (vecs[v]) begin
            do_reset();
            if (vecs[v].prev != 3'd7) begin
                push(int'(vecs[v].prev), DW'($urandom), 1'b1);
                run_idle("tbl_prev", 100);
            end
            for (int i = 0; i < N; i++) if (vecs[v].valid[i]) push(i, DW'($urandom), 1'b1);
            step();
            check("tbl_ready", 32'(last_ready), 32'(vecs[v].ready));
            check("tbl_grant", 32'(grant), 32'(vecs[v].ready));
            run_idle("tbl_drain", 300);
        end

        // three simultaneous requesters, two rounds
        do_reset();
        for (int r = 0; r < 2; r++) begin
            push(0, DW'(8'h10 + r), 1'b1);
            push(1, DW'(8'h20 + r), 1'b1);
            push(3, DW'(8'h30 + r), 1'b1);
        end
        run_idle("t2", 400);
        exp_log = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        check_log("t2");

        // req2 burst holds off req1
        do_reset();
        push(1, 8'h01, 1'b1);
        run_idle("t3_pre", 100);
        svc.delete();
        push(2, 8'h11, 1'b0);
        push(2, 8'h22, 1'b0);
        push(2, 8'h33, 1'b1);
        push(1, 8'h44, 1'b1);
        run_idle("t3", 300);
        exp_log = '{4'b0100, 4'b0100, 4'b0100, 4'b0010};
        check_log("t3");

        // MAX_BURST forced release, then a lock held while the owner goes quiet
        do_reset();
        for (int k = 0; k < 10; k++) push(0, DW'(8'h50 + k), 1'b0);
        push(1, 8'hB1, 1'b1);
        push(1, 8'hB2, 1'b1);
        c = 0;
        while ((svc.size() < 12 || u_state != 0) && c < 600) begin
            step();
            c++;
        end
        if (svc.size() < 12 || u_state != 0) fail_timeout("t4_stream", 600);
        step_n(6);
        check("t4_lock_grant", 32'(grant), 32'h1);
        check("t4_lock_busy", 32'(arb_busy), 32'd1);
        push(1, 8'hB3, 1'b1);
        step_n(10);
        check("t4_lock_ready", 32'(last_ready), 32'd0);
        check("t4_lock_nosend", 32'(svc.size()), 32'd12);
        check("t4_lock_grant2", 32'(grant), 32'h1);
        push(0, 8'hEE, 1'b1);
        run_idle("t4", 300);
        exp_log = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
                    4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
                    4'b0001, 4'b0001, 4'b0001, 4'b0010};
        check_log("t4");

        // tx_busy never rises: watchdog expiry after BT cycles in WAIT_HI
        do_reset();
        stall = 1'b1;
        push(0, 8'h5A, 1'b1);
        step();
        check("t5_tx_start", 32'(tx_start), 32'd1);
        step_n(BT);
        check("t5_err_early", 32'(err_timeout), 32'd0);
        step();
        check("t5_err_set", 32'(err_timeout), 32'd1);
        check("t5_busy_next", 32'(arb_busy), 32'd1);
        step();
        check("t5_grant_rel", 32'(grant), 32'd0);
        check("t5_idle", 32'(arb_busy), 32'd0);
        stall = 1'b0;
        push(1, 8'h3C, 1'b1);
        run_idle("t5_after", 100);
        check("t5_err_sticky", 32'(err_timeout), 32'd1);

        // reset while the frame is in flight
        do_reset();
        push(0, 8'hC3, 1'b1);
        c = 0;
        while (!u_busy && c < 20) begin
            step();
            c++;
        end
        if (!u_busy) fail_timeout("t6_busy", 20);
        u_hi = 10;
        step();
        rst = 1'b1;
        step();
        check("t6_grant", 32'(grant), 32'd0);
        check("t6_arb_busy", 32'(arb_busy), 32'd0);
        check("t6_tx_start", 32'(tx_start), 32'd0);
        check("t6_ready", 32'(last_ready), 32'd0);
        rst = 1'b0;
        u_busy = 1'b0; u_state = 0; prev_start = 1'b0;
        model_reset();
        svc.delete();
        push(3, 8'h69, 1'b1);
        push(0, 8'h96, 1'b1);
        run_idle("t6_after", 200);
        exp_log = '{4'b0001, 4'b1000};
        check_log("t6");

        // random traffic, bytes pushed while the arbiter runs
        for (int it = 0; it < 20; it++) begin
            do_reset();
            for (int cyc = 0; cyc < 150; cyc++) begin
                if ($urandom_range(0, 3) == 0)
                    push($urandom_range(0, N-1), DW'($urandom), ($urandom_range(0, 2) == 0));
                step();
            end
            for (int i = 0; i < N; i++) push(i, DW'($urandom), 1'b1);
            run_idle("rnd", 3000);
            check("rnd_err", 32'(err_timeout), 32'd0);
            check("rnd_arb_busy", 32'(arb_busy), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
